hps_bridge_csr: RTL and testbench

HPS_BRIDGE_CSR -- requirements
Module: hps_bridge_csr

---
 rtl/hps_bridge_csr_pkg.sv | 21 ++
 rtl/bit_sync.sv | 24 ++
 rtl/hps_bridge_csr.sv | 170 +++++++++++++++++
 tb/tb_hps_bridge_csr.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_bridge_csr_pkg.sv
// Shared constants for the HPS bridge CSR block: register byte offsets,
// bus FSM states and control-register bit positions.
package hps_bridge_csr_pkg;

  localparam logic [5:0] OFS_ID       = 6'h00;
  localparam logic [5:0] OFS_SCRATCH  = 6'h04;
  localparam logic [5:0] OFS_LED      = 6'h08;
  localparam logic [5:0] OFS_STATUS   = 6'h0C;
  localparam logic [5:0] OFS_KEY_EDGE = 6'h10;
  localparam logic [5:0] OFS_CYCLES   = 6'h14;
  localparam logic [5:0] OFS_CTRL     = 6'h18;

  localparam int CTRL_CLR_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module bit_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages to let metastability settle before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_bridge_csr.sv
// Avalon-MM burst-capable CSR slave for the HPS bridge: ID, scratch, LEDs,
// synchronized switch/key status, key falling-edge flags and a cycle counter.
module hps_bridge_csr
  import hps_bridge_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'hDE10_0001,
  parameter int          BURST_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [3:0]         avs_byteenable,
  input  logic [BURST_W-1:0] avs_burstcount,
  input  logic               avs_debugaccess,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic               avs_waitrequest,
  output logic [7:0]         led_o,
  input  logic [3:0]         sw_i,
  input  logic [1:0]         key_i
);

  state_t             state;
  logic [3:0]         idx;
  logic [BURST_W-1:0] left;

  logic [3:0]  sw_sync;
  logic [1:0]  key_sync;
  logic [1:0]  key_prev;
  logic [1:0]  key_edge;
  logic [31:0] scratch;
  logic [31:0] cycles;
  logic [7:0]  led;

  logic [BURST_W-1:0] beats;
  logic               idle_acc;
  logic               wr_beat;
  logic               rd_start;
  logic [5:0]         wr_ofs;
  logic [5:0]         rd_ofs;
  logic [31:0]        rd_word;
  logic [1:0]         edge_clr;
  logic               cyc_clr;

  // Byte-lane address bits and debugaccess carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{avs_debugaccess, avs_address[1:0]};

  assign led_o = led;

  bit_sync #(.WIDTH(4)) u_sw_sync (
    .clk (clk),
    .rst (reset),
    .d   (sw_i),
    .q   (sw_sync)
  );

  bit_sync #(.WIDTH(2)) u_key_sync (
    .clk (clk),
    .rst (reset),
    .d   (key_i),
    .q   (key_sync)
  );

  // Command acceptance, beat addressing and the register read mux.
  always_comb begin
    beats    = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    idle_acc = (state == ST_IDLE) && !avs_waitrequest;
    wr_beat  = avs_write && (idle_acc || (state == ST_WR_BURST));
    rd_start = idle_acc && avs_read && !avs_write;
    wr_ofs   = (state == ST_WR_BURST) ? {idx, 2'b00} : {avs_address[5:2], 2'b00};
    rd_ofs   = (state == ST_RD_BURST) ? {idx, 2'b00} : {avs_address[5:2], 2'b00};
    edge_clr = (wr_beat && (wr_ofs == OFS_KEY_EDGE) && avs_byteenable[0])
               ? avs_writedata[1:0] : 2'b00;
    cyc_clr  = wr_beat && (wr_ofs == OFS_CTRL) && avs_byteenable[0]
               && avs_writedata[CTRL_CLR_BIT];
    case (rd_ofs)
      OFS_ID:       rd_word = ID_VALUE;
      OFS_SCRATCH:  rd_word = scratch;
      OFS_LED:      rd_word = {24'd0, led};
      OFS_STATUS:   rd_word = {26'd0, key_sync, sw_sync};
      OFS_KEY_EDGE: rd_word = {30'd0, key_edge};
      OFS_CYCLES:   rd_word = cycles;
      default:      rd_word = 32'd0;
    endcase
  end

  // Bus FSM: one read beat per cycle while bursting, writes stall on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      avs_waitrequest   <= 1'b1;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= 32'd0;
      idx               <= 4'd0;
      left              <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          avs_waitrequest   <= 1'b0;
          avs_readdatavalid <= 1'b0;
          if (idle_acc && avs_write) begin
            if (beats != BURST_W'(1)) begin
              state <= ST_WR_BURST;
              idx   <= avs_address[5:2] + 4'd1;
              left  <= beats - BURST_W'(1);
            end
          end else if (rd_start) begin
            state             <= ST_RD_BURST;
            avs_waitrequest   <= 1'b1;
            avs_readdatavalid <= 1'b1;
            avs_readdata      <= rd_word;
            idx               <= avs_address[5:2] + 4'd1;
            left              <= beats - BURST_W'(1);
          end
        end
        ST_RD_BURST: begin
          if (left == '0) begin
            state             <= ST_IDLE;
            avs_waitrequest   <= 1'b0;
            avs_readdatavalid <= 1'b0;
          end else begin
            avs_readdatavalid <= 1'b1;
            avs_readdata      <= rd_word;
            idx               <= idx + 4'd1;
            left              <= left - BURST_W'(1);
          end
        end
        ST_WR_BURST: begin
          avs_waitrequest   <= 1'b0;
          avs_readdatavalid <= 1'b0;
          if (avs_write) begin
            idx  <= idx + 4'd1;
            left <= left - BURST_W'(1);
            if (left == BURST_W'(1)) state <= ST_IDLE;
          end
        end
        default: begin
          state           <= ST_IDLE;
          avs_waitrequest <= 1'b0;
        end
      endcase
    end
  end

  // Register file: byte-enabled writes, W1C key flags where a new edge wins, cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch  <= 32'd0;
      led      <= 8'd0;
      key_prev <= 2'b00;
      key_edge <= 2'b00;
      cycles   <= 32'd0;
    end else begin
      if (wr_beat && (wr_ofs == OFS_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (avs_byteenable[b]) scratch[8*b +: 8] <= avs_writedata[8*b +: 8];
        end
      end
      if (wr_beat && (wr_ofs == OFS_LED) && avs_byteenable[0]) led <= avs_writedata[7:0];
      key_prev <= key_sync;
      key_edge <= (key_edge & ~edge_clr) | (key_prev & ~key_sync);
      cycles   <= cyc_clr ? 32'd0 : cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hps_bridge_csr.sv
// Testbench for hps_bridge_csr: directed table, burst/key/reset sequences and
// randomized traffic checked against a register-level model.
module tb_hps_bridge_csr;

  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [5:0]         avs_address;
  logic               avs_read;
  logic               avs_write;
  logic [31:0]        avs_writedata;
  logic [3:0]         avs_byteenable;
  logic [BURST_W-1:0] avs_burstcount;
  logic               avs_debugaccess;
  logic [31:0]        avs_readdata;
  logic               avs_readdatavalid;
  logic               avs_waitrequest;
  logic [7:0]         led_o;
  logic [3:0]         sw_i;
  logic [1:0]         key_i;

  hps_bridge_csr #(.ID_VALUE(32'hDE10_0001), .BURST_W(BURST_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_debugaccess   (avs_debugaccess),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .led_o             (led_o),
    .sw_i              (sw_i),
    .key_i             (key_i)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int vectors = 0;
  int miscompares = 0;

  // Register-level reference state
  logic [31:0] m_scratch;
  logic [7:0]  m_led;
  logic [1:0]  m_edge;
  logic [3:0]  m_sw;
  logic [1:0]  m_key;
  int          clr_edge;

  logic [31:0] wd [8];
  logic [31:0] got [8];
  int          got_n;
  int          acc_edge;

  typedef struct {
    logic [5:0]  wa;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [5:0]  ra;
    logic [31:0] exp;
    logic [7:0]  led;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected read value of word i for a beat produced at edge e.
  function automatic logic [31:0] m_read(input logic [3:0] i, input int e);
    case (i)
      4'd0:    return 32'hDE10_0001;
      4'd1:    return m_scratch;
      4'd2:    return {24'd0, m_led};
      4'd3:    return {26'd0, m_key, m_sw};
      4'd4:    return {30'd0, m_edge};
      4'd5:    return 32'(e - 1 - clr_edge);
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [3:0] i, input logic [31:0] d, input logic [3:0] be, input int e);
    case (i)
      4'd1: for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      4'd2: if (be[0]) m_led = d[7:0];
      4'd4: if (be[0]) m_edge = m_edge & ~d[1:0];
      4'd6: if (be[0] && d[0]) clr_edge = e;
      default: ;
    endcase
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] bc, input logic [3:0] be,
                    input bit stall, input bit rd_too);
    int n;
    n = (bc == 4'd0) ? 1 : int'(bc);
    @(negedge clk);
    avs_address = a; avs_burstcount = bc; avs_byteenable = be;
    avs_writedata = wd[0]; avs_write = 1'b1; avs_read = rd_too;
    for (int t = 0; t < 50 && avs_waitrequest; t++) @(negedge clk);
    if (avs_waitrequest) begin
      chk("wr_accept_timeout", 32'd1, 32'd0);
      avs_write = 1'b0; avs_read = 1'b0;
      return;
    end
    @(posedge clk); #1;
    m_write(a[5:2], wd[0], be, edge_n);
    for (int k = 1; k < n; k++) begin
      if (stall && k == 1) begin
        avs_write = 1'b0; avs_writedata = $urandom;
        @(posedge clk); #1;
      end
      avs_write = 1'b1; avs_writedata = wd[k];
      @(posedge clk); #1;
      m_write(a[5:2] + 4'(k), wd[k], be, edge_n);
    end
    avs_write = 1'b0; avs_read = 1'b0;
    if (rd_too) begin
      @(negedge clk);
      chk("wr_dropped_read", 32'(avs_readdatavalid), 32'd0);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [3:0] bc);
    int n;
    n = (bc == 4'd0) ? 1 : int'(bc);
    got_n = 0;
    @(negedge clk);
    avs_address = a; avs_burstcount = bc; avs_read = 1'b1; avs_write = 1'b0;
    for (int t = 0; t < 50 && avs_waitrequest; t++) @(negedge clk);
    if (avs_waitrequest) begin
      chk("rd_accept_timeout", 32'd1, 32'd0);
      avs_read = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_edge = edge_n; avs_read = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rd_valid", 32'(avs_readdatavalid), 32'd1);
      chk("rd_waitreq", 32'(avs_waitrequest), 32'd1);
      got[k] = avs_readdata;
      got_n++;
    end
    @(negedge clk);
    chk("rd_valid_end", 32'(avs_readdatavalid), 32'd0);
    chk("rd_waitreq_end", 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic rd_model(input logic [5:0] a, input logic [3:0] bc, input string nm);
    rd(a, bc);
    for (int k = 0; k < got_n; k++)
      chk(nm, got[k], m_read(a[5:2] + 4'(k), acc_edge + k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    avs_byteenable = 4'hF; avs_burstcount = 4'd1; avs_debugaccess = 1'b0;
    sw_i = 4'hA; key_i = 2'b11;
    m_scratch = '0; m_led = '0; m_edge = '0; m_sw = 4'hA; m_key = 2'b11; clr_edge = 0;

    tbl[0]  = '{6'h04, 32'hA5A5A5A5, 4'b0011, 6'h04, 32'h0000A5A5, 8'h00};
    tbl[1]  = '{6'h04, 32'h12345678, 4'b1100, 6'h04, 32'h1234A5A5, 8'h00};
    tbl[2]  = '{6'h04, 32'hFFFFFFFF, 4'b0000, 6'h04, 32'h1234A5A5, 8'h00};
    tbl[3]  = '{6'h08, 32'hABCDEF5A, 4'b1110, 6'h08, 32'h00000000, 8'h00};
    tbl[4]  = '{6'h08, 32'h0000015A, 4'b0001, 6'h08, 32'h0000005A, 8'h5A};
    tbl[5]  = '{6'h00, 32'hFFFFFFFF, 4'b1111, 6'h00, 32'hDE100001, 8'h5A};
    tbl[6]  = '{6'h3C, 32'h11111111, 4'b1111, 6'h3C, 32'h00000000, 8'h5A};
    tbl[7]  = '{6'h20, 32'h22222222, 4'b1111, 6'h20, 32'h00000000, 8'h5A};
    tbl[8]  = '{6'h18, 32'hFFFFFFFE, 4'b1111, 6'h18, 32'h00000000, 8'h5A};
    tbl[9]  = '{6'h0C, 32'hFFFFFFFF, 4'b1111, 6'h0C, 32'h0000003A, 8'h5A};
    tbl[10] = '{6'h10, 32'h00000003, 4'b1111, 6'h10, 32'h00000000, 8'h5A};
    tbl[11] = '{6'h14, 32'h00000000, 4'b1111, 6'h04, 32'h1234A5A5, 8'h5A};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
    chk("rst_rdvalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_led", 32'(led_o), 32'd0);
    reset = 1'b0;
    clr_edge = edge_n;
    #1 chk("rel_waitreq_hold", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    chk("rel_waitreq_low", 32'(avs_waitrequest), 32'd0);
    repeat (3) @(negedge clk);

    // Single ID read with one-cycle latency
    rd(6'h00, 4'd1);
    chk("id_read", got[0], 32'hDE10_0001);
    rd(6'h00, 4'd0);
    chk("id_read_bc0", got[0], 32'hDE10_0001);
    chk("id_read_bc0_beats", 32'(got_n), 32'd1);

    // Table-driven write/readback
    for (int i = 0; i < 12; i++) begin
      wd[0] = tbl[i].wdat;
      wr(tbl[i].wa, 4'd1, tbl[i].be, 1'b0, 1'b0);
      rd(tbl[i].ra, 4'd1);
      chk($sformatf("tbl%0d_data", i), got[0], tbl[i].exp);
      chk($sformatf("tbl%0d_led", i), 32'(led_o), 32'(tbl[i].led));
    end

    // CYCLES clear, then free-running count
    wd[0] = 32'h1;
    wr(6'h18, 4'd1, 4'hF, 1'b0, 1'b0);
    rd(6'h14, 4'd1);
    chk("cycles_after_clr", got[0], 32'd0);
    repeat (5) @(negedge clk);
    rd_model(6'h14, 4'd1, "cycles_count");
    wr(6'h18, 4'd1, 4'b1110, 1'b0, 1'b0);
    rd_model(6'h14, 4'd1, "cycles_clr_masked");

    // Read burst across unmapped words, then one wrapping modulo 16
    rd(6'h18, 4'd8);
    chk("burst8_beats", 32'(got_n), 32'd8);
    for (int k = 0; k < got_n; k++) chk("burst8_unmapped", got[k], 32'd0);
    rd_model(6'h38, 4'd8, "burst8_wrap");

    // Key falling edges and W1C race
    @(negedge clk); key_i[0] = 1'b0; m_key = 2'b10;
    repeat (4) @(negedge clk);
    rd(6'h10, 4'd1);
    chk("key_edge_set", got[0], 32'd1);
    wd[0] = 32'h1;
    wr(6'h10, 4'd1, 4'hF, 1'b0, 1'b0);
    rd(6'h10, 4'd1);
    chk("key_edge_clr", got[0], 32'd0);
    @(negedge clk); key_i[0] = 1'b1; m_key = 2'b11;
    repeat (4) @(negedge clk);
    @(negedge clk); key_i[0] = 1'b0; m_key = 2'b10;
    @(negedge clk);
    wr(6'h10, 4'd1, 4'hF, 1'b0, 1'b0);
    rd(6'h10, 4'd1);
    chk("key_edge_race", got[0], 32'd1);
    wr(6'h10, 4'd1, 4'b1110, 1'b0, 1'b0);
    rd(6'h10, 4'd1);
    chk("key_edge_be_masked", got[0], 32'd1);
    wr(6'h10, 4'd1, 4'hF, 1'b0, 1'b0);
    rd(6'h10, 4'd1);
    chk("key_edge_later_clr", got[0], 32'd0);
    @(negedge clk); key_i[1] = 1'b0; m_key = 2'b00;
    repeat (4) @(negedge clk);
    rd(6'h10, 4'd1);
    chk("key1_edge_set", got[0], 32'd2);
    m_edge = 2'b10;

    // Write burst of 4 with a stall
    wd[0] = 32'hCAFEF00D; wd[1] = 32'h000000C3; wd[2] = 32'hFFFFFFFF; wd[3] = 32'h00000002;
    wr(6'h04, 4'd4, 4'hF, 1'b1, 1'b0);
    rd(6'h04, 4'd1);
    chk("wburst_scratch", got[0], 32'hCAFEF00D);
    chk("wburst_led", 32'(led_o), 32'h000000C3);
    rd(6'h10, 4'd1);
    chk("wburst_key_edge", got[0], 32'd0);
    rd_model(6'h14, 4'd1, "wburst_cycles");
    rd_model(6'h0C, 4'd1, "wburst_status");
    @(negedge clk); key_i = 2'b11; m_key = 2'b11;
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      avs_debugaccess = 1'($urandom);
      if ($urandom_range(7) == 0) begin
        m_sw = 4'($urandom); sw_i = m_sw;
        repeat (4) @(negedge clk);
      end
      if ($urandom_range(2) != 0) begin
        for (int k = 0; k < 8; k++) wd[k] = $urandom;
        wr({4'($urandom_range(15)), 2'b00}, 4'($urandom_range(4)), 4'($urandom),
           1'($urandom), 1'($urandom));
      end else begin
        rd_model({4'($urandom_range(15)), 2'($urandom)}, 4'($urandom_range(8)), "rand_read");
      end
    end

    // Reset in the middle of an 8-beat read
    wd[0] = 32'hFF;
    wr(6'h08, 4'd1, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    avs_address = 6'h00; avs_burstcount = 4'd8; avs_read = 1'b1;
    for (int t = 0; t < 50 && avs_waitrequest; t++) @(negedge clk);
    @(posedge clk); #1;
    avs_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_pre_valid", 32'(avs_readdatavalid), 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rdvalid", 32'(avs_readdatavalid), 32'd0);
    chk("abort_led", 32'(led_o), 32'd0);
    chk("abort_readdata", avs_readdata, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_hold_rdvalid", 32'(avs_readdatavalid), 32'd0);
      chk("abort_hold_waitreq", 32'(avs_waitrequest), 32'd1);
    end
    reset = 1'b0;
    clr_edge = edge_n;
    m_scratch = '0; m_led = '0; m_edge = '0;
    #1 chk("abort_rel_waitreq", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    chk("abort_rel_waitreq_low", 32'(avs_waitrequest), 32'd0);
    chk("abort_rel_rdvalid", 32'(avs_readdatavalid), 32'd0);
    repeat (3) @(negedge clk);
    rd_model(6'h04, 4'd1, "post_rst_scratch");
    rd_model(6'h08, 4'd1, "post_rst_led");
    rd_model(6'h0C, 4'd3, "post_rst_regs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
